// File: rtl/move_pkg.sv
// ---------------------------------------------------------------------------
// move_pkg
// Shared types and constants for the move receiver: the receive FSM state
// type, the width of a move, the board size and a helper that turns a cell
// index into a one-hot board mask.
// Ports: none (package).
// ---------------------------------------------------------------------------
package move_pkg;

  localparam int MOVE_W    = 4;
  localparam int NUM_CELLS = 9;
  localparam int MAX_CELL  = 8;

  typedef enum logic [1:0] {
    WAIT_REQ,
    ACK_HI,
    CHECK,
    DONE
  } rxState_e;

  // One-hot mask of a cell; indices past the last cell shift out to zero.
  function automatic logic [NUM_CELLS-1:0] cellMask(input logic [MOVE_W-1:0] idx);
    cellMask = NUM_CELLS'(1) << idx;
  endfunction

endpackage

// File: rtl/move_receiver_if.sv
// ---------------------------------------------------------------------------
// move_receiver_if
// Bundles the sender handshake, the consumer handshake and the board status
// of the move receiver.
// Signals:
//   dt          sender data-request strobe (4-phase)
//   bit0        serial data bit, valid while dt=1
//   ack         receiver acknowledge to the sender
//   move_taken  consumer has taken the presented move
//   clear_board clears the occupancy mask
//   move        received cell index
//   move_valid  one-cycle pulse when a legal move is presented
//   senack      a legal move is held and awaits move_taken
//   move_err    one-cycle pulse when a frame is rejected
//   occupied    cells already claimed by received moves
// Modports: master (sender/consumer side), slave (receiver side).
// ---------------------------------------------------------------------------
interface move_receiver_if;
  import move_pkg::*;

  logic                 dt;
  logic                 bit0;
  logic                 ack;
  logic                 move_taken;
  logic                 clear_board;
  logic [MOVE_W-1:0]    move;
  logic                 move_valid;
  logic                 senack;
  logic                 move_err;
  logic [NUM_CELLS-1:0] occupied;

  modport master (
    output dt, bit0, move_taken, clear_board,
    input  ack, move, move_valid, senack, move_err, occupied
  );

  modport slave (
    input  dt, bit0, move_taken, clear_board,
    output ack, move, move_valid, senack, move_err, occupied
  );

endinterface

// File: rtl/move_receiver_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk   rising-edge clock
//   reset synchronous active-high reset (clears both flops)
//   i_d   asynchronous input
//   o_q   synchronized output, two clocks behind i_d
// ---------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/move_receiver.sv
// ---------------------------------------------------------------------------
// move_receiver
// Receives 4-bit moves MSB first over a 4-phase dt/ack handshake (one
// handshake per bit), rejects values past the last cell or already-claimed
// cells, presents legal moves with move_valid/senack until move_taken, and
// keeps the board occupancy mask.
// Ports:
//   clk   rising-edge clock
//   reset synchronous active-high reset
//   bus   move_receiver_if.slave (dt, bit0, move_taken, clear_board in;
//         ack, move, move_valid, senack, move_err, occupied out)
// Build option:
//   MOVE_RX_SYNC_EN  when defined, dt and bit0 pass through sync2
//                    synchronizers (every dt-related latency grows by 2).
// ---------------------------------------------------------------------------
module move_receiver
  import move_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  move_receiver_if.slave bus
);

  logic w_dt;
  logic w_bit0;

`ifdef MOVE_RX_SYNC_EN
  sync2 u_syncDt (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.dt),
    .o_q   (w_dt)
  );

  sync2 u_syncBit0 (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.bit0),
    .o_q   (w_bit0)
  );
`else
  assign w_dt   = bus.dt;
  assign w_bit0 = bus.bit0;
`endif

  rxState_e             r_state;
  rxState_e             w_nextState;
  logic [1:0]           r_count;
  logic [MOVE_W-1:0]    r_shift;
  logic [MOVE_W-1:0]    r_move;
  logic                 r_moveValid;
  logic                 r_senack;
  logic                 r_moveErr;
  logic [NUM_CELLS-1:0] r_occupied;
  logic [NUM_CELLS-1:0] w_cellMask;
  logic [NUM_CELLS-1:0] w_board;
  logic                 w_legal;
  logic                 w_sample;
  logic                 w_bitDone;
  logic                 w_accept;
  logic                 w_reject;
  logic                 w_release;

  // A board cleared in the same cycle as the check counts as empty, so a
  // move onto a cell that is being cleared is accepted.
  assign w_cellMask = cellMask(r_shift);
  assign w_board    = bus.clear_board ? '0 : r_occupied;
  assign w_legal    = (int'(r_shift) <= MAX_CELL) && ((w_board & w_cellMask) == '0);

  // Next-state and per-cycle control strobes for the receive handshake.
  // In DONE, dt is deliberately ignored so the sender is held off until the
  // consumer takes the move.
  always_comb begin
    w_nextState = r_state;
    w_sample    = 1'b0;
    w_bitDone   = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      WAIT_REQ: begin
        if (w_dt) begin
          w_sample    = 1'b1;
          w_nextState = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!w_dt) begin
          w_bitDone   = 1'b1;
          w_nextState = (r_count == 2'd3) ? CHECK : WAIT_REQ;
        end
      end
      CHECK: begin
        if (w_legal) begin
          w_accept    = 1'b1;
          w_nextState = DONE;
        end else begin
          w_reject    = 1'b1;
          w_nextState = WAIT_REQ;
        end
      end
      DONE: begin
        if (bus.move_taken) begin
          w_release   = 1'b1;
          w_nextState = WAIT_REQ;
        end
      end
      default: w_nextState = WAIT_REQ;
    endcase
  end

  // State, shift register, bit counter and presented move. The 2-bit
  // counter wraps to zero on the fourth bit, so every frame starts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= WAIT_REQ;
      r_count     <= 2'd0;
      r_shift     <= '0;
      r_move      <= '0;
      r_moveValid <= 1'b0;
      r_senack    <= 1'b0;
      r_moveErr   <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_moveValid <= w_accept;
      r_moveErr   <= w_reject;
      if (w_sample) begin
        r_shift <= {r_shift[MOVE_W-2:0], w_bit0};
      end
      if (w_bitDone) begin
        r_count <= r_count + 2'd1;
      end
      if (w_accept) begin
        r_move   <= r_shift;
        r_senack <= 1'b1;
      end else if (w_release) begin
        r_senack <= 1'b0;
      end
    end
  end

  // Board occupancy. A clear coinciding with an accepted move leaves only
  // the newly claimed cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occupied <= '0;
    end else if (bus.clear_board) begin
      r_occupied <= w_accept ? w_cellMask : '0;
    end else if (w_accept) begin
      r_occupied <= r_occupied | w_cellMask;
    end
  end

  assign bus.ack        = (r_state == ACK_HI);
  assign bus.move       = r_move;
  assign bus.move_valid = r_moveValid;
  assign bus.senack     = r_senack;
  assign bus.move_err   = r_moveErr;
  assign bus.occupied   = r_occupied;

endmodule

// File: tb/tb_move_receiver.sv
// ---------------------------------------------------------------------------
// tb_move_receiver
// Self-checking bench for move_receiver: a table of frames with hand-derived
// outcomes, hand-written sequences for reset mid-frame, backpressure in DONE
// and a clear coinciding with the check, then random frames compared with a
// board model kept as a plain integer bitmap.
// Honours MOVE_RX_SYNC_EN for the expected latencies.
// ---------------------------------------------------------------------------
module tb_move_receiver;

`ifdef MOVE_RX_SYNC_EN
  localparam int ACK_LAT   = 3;
  localparam int VALID_LAT = 4;
`else
  localparam int ACK_LAT   = 1;
  localparam int VALID_LAT = 2;
`endif
  localparam int MAX_WAIT   = 20;
  localparam int NUM_RANDOM = 60;

  typedef struct {
    int         value;
    bit         clearBefore;
    bit         clearAtCheck;
    bit         expValid;
    logic [8:0] expOcc;
  } vec_t;

  logic clk;
  logic reset;
  int   checks      = 0;
  int   failures    = 0;
  int   cyc         = 0;
  int   validCount  = 0;
  int   errCount    = 0;
  int   validCyc    = 0;
  int   lastDropCyc = 0;
  vec_t vecs[10];

  move_receiver_if bus();

  move_receiver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure latencies.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Pulse monitor: counts every cycle a pulse output is high.
  always @(negedge clk) begin
    if (bus.move_valid === 1'b1) begin
      validCount = validCount + 1;
      validCyc   = cyc;
    end
    if (bus.move_err === 1'b1) begin
      errCount = errCount + 1;
    end
  end

  // Safety net in case a handshake never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitAck(input logic level, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      tick();
      if (bus.ack === level) begin
        lat = n;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  // One full 4-phase handshake for a single bit. With jitter, idle gaps,
  // dt hold times, stray move_taken and bit0 changes while dt is low are
  // randomised.
  task automatic sendBit(input logic b, input bit jitter);
    int lat;
    bit ok;
    int hold;
    if (jitter) begin
      repeat ($urandom_range(0, 2)) tick();
      bus.move_taken = 1'($urandom_range(0, 1));
    end
    bus.bit0 = b;
    bus.dt   = 1'b1;
    waitAck(1'b1, lat, ok);
    checkOutput("ackRiseLat", lat, ACK_LAT);
    hold = jitter ? int'($urandom_range(0, 3)) : 0;
    repeat (hold) begin
      tick();
      checkOutput("ackHold", bus.ack, 1);
    end
    bus.dt      = 1'b0;
    lastDropCyc = cyc;
    if (jitter) begin
      bus.bit0 = 1'($urandom_range(0, 1));
    end
    waitAck(1'b0, lat, ok);
    checkOutput("ackFallLat", lat, ACK_LAT);
    bus.move_taken = 1'b0;
  endtask

  task automatic awaitOutcome(input int vB, input int eB, output int nV, output int nE);
    for (int n = 0; n < MAX_WAIT; n++) begin
      if (validCount != vB || errCount != eB) break;
      tick();
    end
    tick();
    tick();
    nV = validCount - vB;
    nE = errCount - eB;
  endtask

  task automatic applyStimulus(input int v, input bit clearBefore, input bit clearAtCheck,
                               input bit jitter, output int nV, output int nE);
    int         vB;
    int         eB;
    logic [3:0] bits;
    bits = 4'(v);
    if (clearBefore) begin
      bus.clear_board = 1'b1;
      tick();
      bus.clear_board = 1'b0;
    end
    vB = validCount;
    eB = errCount;
    repeat (4) begin
      sendBit(bits[3], jitter);
      bits = {bits[2:0], 1'b0};
    end
    if (clearAtCheck) begin
      bus.clear_board = 1'b1;
      tick();
      bus.clear_board = 1'b0;
    end
    awaitOutcome(vB, eB, nV, nE);
  endtask

  task automatic takeMove(input string tag);
    bus.move_taken = 1'b1;
    tick();
    bus.move_taken = 1'b0;
    checkOutput({tag, ".senackClr"}, bus.senack, 0);
  endtask

  task automatic checkFrame(input string tag, input int v, input bit expValid,
                            input logic [8:0] expOcc, input int nV, input int nE,
                            input bit take);
    checkOutput({tag, ".validPulses"}, nV, expValid ? 1 : 0);
    checkOutput({tag, ".errPulses"}, nE, expValid ? 0 : 1);
    checkOutput({tag, ".occupied"}, bus.occupied, expOcc);
    checkOutput({tag, ".senack"}, bus.senack, expValid);
    if (expValid) begin
      checkOutput({tag, ".move"}, bus.move, v);
      checkOutput({tag, ".validLat"}, validCyc - lastDropCyc, VALID_LAT);
      if (take) takeMove(tag);
    end
  endtask

  // Random frames against a board model: a frame is legal when its value
  // names a cell and that cell is free on the board as seen after any clear.
  task automatic runRandom(input int startOcc);
    int refOcc;
    int v;
    int board;
    int nV;
    int nE;
    bit cb;
    bit cc;
    bit expV;
    refOcc = startOcc;
    for (int f = 0; f < NUM_RANDOM; f++) begin
      v  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      cb = ($urandom_range(0, 7) == 0);
      cc = ($urandom_range(0, 7) == 0);
      if (cb) refOcc = 0;
      board  = cc ? 0 : refOcc;
      expV   = (v <= 8) && (((board >> v) & 1) == 0);
      refOcc = expV ? (board | (1 << v)) : board;
      applyStimulus(v, cb, cc, 1'b1, nV, nE);
      checkFrame($sformatf("rnd%0d", f), v, expV, refOcc[8:0], nV, nE, 1'b1);
    end
  endtask

  initial begin
    int nV;
    int nE;
    int vB;
    int eB;
    int lat;
    bit ok;
    bit ackSeen;
    int occ;

    reset           = 1'b1;
    bus.dt          = 1'b0;
    bus.bit0        = 1'b0;
    bus.move_taken  = 1'b0;
    bus.clear_board = 1'b0;
    repeat (3) tick();
    checkOutput("rst.ack", bus.ack, 0);
    checkOutput("rst.move", bus.move, 0);
    checkOutput("rst.moveValid", bus.move_valid, 0);
    checkOutput("rst.senack", bus.senack, 0);
    checkOutput("rst.moveErr", bus.move_err, 0);
    checkOutput("rst.occupied", bus.occupied, 0);
    reset = 1'b0;
    tick();

    // value, clearBefore, clearAtCheck, expValid, expOcc
    vecs[0] = '{5,  1'b0, 1'b0, 1'b1, 9'h020};
    vecs[1] = '{5,  1'b0, 1'b0, 1'b0, 9'h020};
    vecs[2] = '{15, 1'b0, 1'b0, 1'b0, 9'h020};
    vecs[3] = '{8,  1'b0, 1'b0, 1'b1, 9'h120};
    vecs[4] = '{0,  1'b0, 1'b0, 1'b1, 9'h121};
    vecs[5] = '{9,  1'b0, 1'b0, 1'b0, 9'h121};
    vecs[6] = '{8,  1'b0, 1'b0, 1'b0, 9'h121};
    vecs[7] = '{8,  1'b1, 1'b0, 1'b1, 9'h100};
    vecs[8] = '{3,  1'b0, 1'b0, 1'b1, 9'h108};
    vecs[9] = '{3,  1'b0, 1'b1, 1'b1, 9'h008};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].value, vecs[i].clearBefore, vecs[i].clearAtCheck, 1'b0, nV, nE);
      checkFrame($sformatf("vec%0d", i), vecs[i].value, vecs[i].expValid,
                 vecs[i].expOcc, nV, nE, 1'b1);
    end

    // Reset after two bits discards them; the next frame decodes cleanly.
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("midRst.occupied", bus.occupied, 0);
    checkOutput("midRst.senack", bus.senack, 0);
    applyStimulus(3, 1'b0, 1'b0, 1'b0, nV, nE);
    checkFrame("midRst", 3, 1'b1, 9'h008, nV, nE, 1'b0);

    // Backpressure: dt raised while a move is held is not acked until taken.
    bus.bit0 = 1'b0;
    bus.dt   = 1'b1;
    ackSeen  = 1'b0;
    repeat (6) begin
      tick();
      if (bus.ack === 1'b1) ackSeen = 1'b1;
    end
    checkOutput("bp.ackBlocked", ackSeen, 0);
    checkOutput("bp.senackHeld", bus.senack, 1);
    checkOutput("bp.moveHeld", bus.move, 3);
    vB = validCount;
    eB = errCount;
    bus.move_taken = 1'b1;
    tick();
    bus.move_taken = 1'b0;
    checkOutput("bp.senackClr", bus.senack, 0);
    waitAck(1'b1, lat, ok);
    checkOutput("bp.ackAfterTake", ok, 1);
    bus.dt = 1'b0;
    waitAck(1'b0, lat, ok);
    checkOutput("bp.ackFall", ok, 1);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b0, 1'b0);
    awaitOutcome(vB, eB, nV, nE);
    checkFrame("bp", 4, 1'b1, 9'h018, nV, nE, 1'b1);

    // Fill the whole board, then clear it in the same cycle as checking 0.
    occ = 0;
    for (int c = 0; c < 9; c++) begin
      occ = occ | (1 << c);
      applyStimulus(c, (c == 0), 1'b0, 1'b0, nV, nE);
      checkFrame($sformatf("fill%0d", c), c, 1'b1, occ[8:0], nV, nE, 1'b1);
    end
    applyStimulus(0, 1'b0, 1'b1, 1'b0, nV, nE);
    checkFrame("clrAtCheck", 0, 1'b1, 9'h001, nV, nE, 1'b1);

    runRandom(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_receiver.md
MOVE_RECEIVER -- requirements
Module: move_receiver

Interface
REQ-001 The block SHALL use a single clock, clk, and reset, which is synchronous and active-high.
REQ-002 Port `clk`: input, 1 bit, rising-edge clock.
REQ-003 Port `reset`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `dt`: input, 1 bit, sender data-request strobe (4-phase).
REQ-005 Port `bit0`: input, 1 bit, serial data bit, valid while dt=1.
REQ-006 Port `ack`: output, 1 bit, receiver acknowledge to sender.
REQ-007 Port `move_taken`: input, 1 bit, consumer has taken the presented move.
REQ-008 Port `clear_board`: input, 1 bit, clears the occupancy mask.
REQ-009 Port `move`: output, 4 bits, received cell index, MSB received first.
REQ-010 Port `move_valid`: output, 1 bit, one-cycle pulse when a legal move is presented.
REQ-011 Port `senack`: output, 1 bit, level; a legal move is held and awaits move_taken.
REQ-012 Port `move_err`: output, 1 bit, one-cycle pulse when a frame is rejected.
REQ-013 Port `occupied`: output, 9 bits, cells already claimed by received moves.

Function
REQ-014 Frame: 4 bits, MSB first; each bit is one 4-phase handshake (dt up, ack up, dt down, ack down).
REQ-015 States SHALL be WAIT_REQ, ACK_HI, CHECK, DONE, with a 2-bit bit counter.
REQ-016 WAIT_REQ with dt=1: shift bit0 into the shift register, go to ACK_HI; ack=1 from the next cycle.
REQ-017 ACK_HI with dt=0: ack=0 next cycle; if counter=3 go to CHECK, else increment the counter and go to WAIT_REQ.
REQ-018 ACK_HI with dt=1: hold ack=1, no sampling (no double-count).
REQ-019 CHECK, one cycle: if value>8 or the cell is already set in occupied, pulse move_err and return to WAIT_REQ with counter=0.
REQ-020 CHECK, legal value: set the occupied bit, load move, pulse move_valid, set senack=1, go to DONE.
REQ-021 DONE: move and senack held; dt ignored and not acked (backpressure); move_taken=1 clears senack next cycle and returns to WAIT_REQ.
REQ-022 move_taken outside DONE SHALL be ignored.
REQ-023 clear_board=1 clears occupied next cycle; if coincident with an accepting CHECK, occupied SHALL become only the new cell.
REQ-024 Latency: dt rise to ack rise = 1 cycle; final dt fall to move_valid = 2 cycles (without sync).

Reset
REQ-025 reset SHALL be sampled only on the clk edge and SHALL take priority over all other inputs.
REQ-026 Reset values: state=WAIT_REQ, counter=0, ack=0, move=0, move_valid=0, senack=0, move_err=0, occupied=0.
REQ-027 Reset mid-frame SHALL discard partial bits; the sender must restart the frame.

Configuration
REQ-028 When MOVE_RX_SYNC_EN is defined, dt and bit0 SHALL pass through 2-flop synchronizers and every dt-related latency SHALL increase by 2 cycles.
REQ-029 When MOVE_RX_SYNC_EN is undefined, dt and bit0 SHALL be used directly and be synchronous to clk.

Structure
REQ-030 Shared package move_pkg SHALL hold the state enum, MOVE_W=4, NUM_CELLS=9, and MAX_CELL=8.
REQ-031 Sub-module sync2 (2-flop synchronizer, 1 bit) SHALL be instantiated twice, only under MOVE_RX_SYNC_EN.
REQ-032 The top level SHALL contain the FSM, shift register, counter, and occupancy mask.

Verification
REQ-033 Send bits 0,1,0,1 (5) -> ack for each bit, move=5, move_valid pulse, senack=1, occupied=9'h020.
REQ-034 After REQ-033, pulse move_taken, then send 5 again -> move_err pulse, occupied unchanged, senack=0.
REQ-035 Send 1,1,1,1 (15) -> move_err, no move_valid, FSM in WAIT_REQ.
REQ-036 In DONE, raise dt -> ack stays 0 until move_taken; then that bit is accepted normally.
REQ-037 Assert reset after 2 bits, then send 0,0,1,1 -> move=3, occupied=9'h008.
REQ-038 clear_board coincident with CHECK of move 0 while occupied=9'h1FF -> occupied=9'h001.
